// File: rtl/mem_arb_pkg.sv
// Shared state encoding and constants for the IF/MEM unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusyIf  = 2'd1,
        StBusyMem = 2'd2,
        StDrain   = 2'd3
    } arb_state_e;

    localparam logic [3:0]  BE_WORD  = 4'hF;
    localparam int unsigned STARVE_W = 8;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of MEM grants taken while IF was waiting; at_limit forces an IF win.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_MEM_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] Limit = STARVE_W'(MAX_MEM_BURST);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != Limit)) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and load/store,
// returning read data with one-cycle ready pulses and cancelling fetches on taken branches.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_MEM_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_be,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e state_q, state_d;

    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [3:0]        m_be_q;
    logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
    logic              if_ready_q, mem_ready_q;

    logic if_elig, mem_elig, at_limit;
    logic grant_if, grant_mem, if_done, mem_done;

    // A requester just handed its ready pulse still shows stale operands this cycle.
    assign if_elig  = if_req & ~if_ready & ~if_flush;
    assign mem_elig = mem_req & ~mem_ready;

    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if_done   = 1'b0;
        mem_done  = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_elig && !(if_elig && at_limit)) begin
                    grant_mem = 1'b1;
                    state_d   = StBusyMem;
                end else if (if_elig) begin
                    grant_if = 1'b1;
                    state_d  = StBusyIf;
                end
            end
            StBusyIf: begin
                // A flush coinciding with the ack simply discards the fetched word.
                if (m_ack) begin
                    if_done = ~if_flush;
                    state_d = StIdle;
                end else if (if_flush) begin
                    state_d = StDrain;
                end
            end
            StBusyMem: begin
                if (m_ack) begin
                    mem_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            StDrain: begin
                if (m_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_be_q      <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_ready_q  <= if_done;
            mem_ready_q <= mem_done;
            if (grant_mem) begin
                m_we_q    <= mem_we;
                m_addr_q  <= mem_addr;
                m_wdata_q <= mem_wdata;
                m_be_q    <= mem_be;
            end else if (grant_if) begin
                m_we_q    <= 1'b0;
                m_addr_q  <= if_addr;
                m_wdata_q <= '0;
                m_be_q    <= BE_WORD;
            end
            if (if_done) begin
                if_rdata_q <= m_rdata;
            end
            if (mem_done) begin
                mem_rdata_q <= m_rdata;
            end
        end
    end

    mem_arb_starve_cnt #(
        .MAX_MEM_BURST(MAX_MEM_BURST)
    ) u_starve_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (grant_mem & if_req),
        .clr     (grant_if | ~if_req),
        .at_limit(at_limit)
    );

    assign m_req     = (state_q != StIdle);
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_be      = m_be_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q & ~if_flush;
    assign mem_ready = mem_ready_q;
    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = mem_req & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected grants and read data are queued as requests are driven
// and checked as the arbiter issues memory accesses and ready pulses.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_ready, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_ready, mem_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_MEM_BURST(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .if_stall (if_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_stall(mem_stall),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } grant_t;

    grant_t      grant_q[$];
    logic [31:0] if_exp_q[$];
    logic [31:0] mem_exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 0;
    int wait_cnt = 0;
    int last_grant_cyc    = 0;
    int last_mem_ready_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    function automatic void exp_if(input logic [31:0] addr);
        grant_t g;
        g = '{we: 1'b0, addr: addr, wdata: 32'h0, be: 4'hF};
        grant_q.push_back(g);
        if_exp_q.push_back(mem_word(addr));
    endfunction

    function automatic void exp_mem(input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be);
        grant_t g;
        g = '{we: we, addr: addr, wdata: wdata, be: be};
        grant_q.push_back(g);
        mem_exp_q.push_back(mem_word(addr));
    endfunction

    always @(posedge clk) cyc++;

    // Memory model: acks after `lat` extra wait cycles, data is a function of the address.
    always @(posedge clk) begin
        #1;
        if (m_req) begin
            if (wait_cnt == lat) begin
                m_ack    = 1'b1;
                m_rdata  = mem_word(m_addr);
                wait_cnt = 0;
            end else begin
                m_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            m_ack    = 1'b0;
            wait_cnt = 0;
        end
    end

    logic        req_prev = 1'b0;
    logic        ack_prev = 1'b0;
    grant_t      cap;

    always @(negedge clk) begin
        grant_t g;
        if (m_req && !req_prev) begin
            check_eq("grant_pending", 32'(grant_q.size() != 0), 32'd1);
            if (grant_q.size() != 0) begin
                g = grant_q.pop_front();
                check_eq("m_addr", m_addr, g.addr);
                check_eq("m_we", 32'(m_we), 32'(g.we));
                check_eq("m_be", 32'(m_be), 32'(g.be));
                if (g.we) check_eq("m_wdata", m_wdata, g.wdata);
            end
            cap = '{we: m_we, addr: m_addr, wdata: m_wdata, be: m_be};
            last_grant_cyc = cyc;
        end else if (m_req) begin
            check_eq("m_addr_stable", m_addr, cap.addr);
            check_eq("m_ctl_stable", {27'h0, m_we, m_be}, {27'h0, cap.we, cap.be});
        end
        if (if_ready) begin
            check_eq("if_ready_after_ack", 32'(ack_prev), 32'd1);
            check_eq("if_exp_pending", 32'(if_exp_q.size() != 0), 32'd1);
            if (if_exp_q.size() != 0) check_eq("if_rdata", if_rdata, if_exp_q.pop_front());
        end
        if (mem_ready) begin
            check_eq("mem_ready_after_ack", 32'(ack_prev), 32'd1);
            check_eq("mem_exp_pending", 32'(mem_exp_q.size() != 0), 32'd1);
            if (mem_exp_q.size() != 0) check_eq("mem_rdata", mem_rdata, mem_exp_q.pop_front());
            last_mem_ready_cyc = cyc;
        end
        req_prev = m_req;
        ack_prev = m_ack & m_req;
    end

    // Called just after a rising edge; returns just after the edge following the ready pulse.
    task automatic if_access(input logic [31:0] addr);
        bit done;
        done    = 1'b0;
        if_addr = addr;
        if_req  = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (i == 0) check_eq("if_stall_wait", 32'(if_stall), 32'd1);
            if (if_ready) begin
                check_eq("if_stall_ready", 32'(if_stall), 32'd0);
                if_req = 1'b0;
                done   = 1'b1;
            end
        end
        check_eq("if_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        bit done;
        done      = 1'b0;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_be    = be;
        mem_req   = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (i == 0) check_eq("mem_stall_wait", 32'(mem_stall), 32'd1);
            if (mem_ready) begin
                check_eq("mem_stall_ready", 32'(mem_stall), 32'd0);
                mem_req = 1'b0;
                done    = 1'b1;
            end
        end
        check_eq("mem_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
        m_ack = 1'b0; m_rdata = '0;

        // Reset state; stalls follow the request inputs even while in reset.
        repeat (3) @(posedge clk);
        #1;
        if_req = 1'b1;
        #1;
        check_eq("rst_m_req", 32'(m_req), 32'd0);
        check_eq("rst_ready", {30'h0, if_ready, mem_ready}, 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'd0);
        check_eq("rst_m_addr", m_addr, 32'd0);
        check_eq("rst_if_stall", 32'(if_stall), 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Plain fetch with a slow memory.
        lat = 3;
        exp_if(32'h100);
        if_access(32'h100);

        // Store and fetch together: MEM first, IF granted on the mem_ready cycle.
        lat = 1;
        exp_mem(1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011);
        exp_if(32'h104);
        fork
            mem_access(1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011);
            if_access(32'h104);
        join
        check_eq("if_after_mem_ready", last_grant_cyc, last_mem_ready_cyc + 1);

        // Starvation: five MEM grants while IF waits (held off by flush) saturate at four.
        lat      = 0;
        if_addr  = 32'h180;
        if_req   = 1'b1;
        if_flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_mem(1'b0, 32'h310 + 32'(4 * i), 32'h0, 4'hF);
            mem_access(1'b0, 32'h310 + 32'(4 * i), 32'h0, 4'hF);
        end
        if_flush = 1'b0;
        exp_if(32'h180);
        exp_mem(1'b0, 32'h330, 32'h0, 4'hF);
        fork
            if_access(32'h180);
            mem_access(1'b0, 32'h330, 32'h0, 4'hF);
        join
        // Counter cleared again: MEM wins the tie.
        exp_mem(1'b1, 32'h324, 32'hCAFEF00D, 4'b1100);
        exp_if(32'h184);
        fork
            mem_access(1'b1, 32'h324, 32'hCAFEF00D, 4'b1100);
            if_access(32'h184);
        join

        // Flush in the ready cycle suppresses the pulse but the word was captured.
        lat     = 0;
        grant_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, be: 4'hF});
        if_addr = 32'h400;
        if_req  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        @(negedge clk);
        check_eq("flush_suppress_ready", 32'(if_ready), 32'd0);
        if_req = 1'b0;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        check_eq("flush_rdata_kept", if_rdata, mem_word(32'h400));

        // Flush while busy on a fetch: drain, no ready, then refetch from the new PC.
        lat = 4;
        grant_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, be: 4'hF});
        if_addr = 32'h200;
        if_req  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        if_addr  = 32'h40;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        begin
            bit dropped;
            dropped = 1'b0;
            for (int i = 0; i < 20 && !dropped; i++) begin
                @(negedge clk);
                if (!m_req) dropped = 1'b1;
            end
            check_eq("drain_done", 32'(dropped), 32'd1);
        end
        check_eq("drain_no_ready", 32'(if_ready), 32'd0);
        check_eq("drain_rdata_held", if_rdata, mem_word(32'h400));
        exp_if(32'h40);
        @(posedge clk);
        #1;
        if_access(32'h40);

        // Load unaffected by flush toggling.
        lat = 3;
        exp_mem(1'b0, 32'h300, 32'h0, 4'hF);
        fork
            mem_access(1'b0, 32'h300, 32'h0, 4'hF);
            begin
                for (int i = 0; i < 6; i++) begin
                    if_flush = ~if_flush;
                    @(posedge clk);
                    #1;
                end
                if_flush = 1'b0;
            end
        join

        // Reset in the middle of a MEM access.
        lat = 10;
        grant_q.push_back('{we: 1'b1, addr: 32'h500, wdata: 32'h12345678, be: 4'hC});
        mem_we    = 1'b1;
        mem_addr  = 32'h500;
        mem_wdata = 32'h12345678;
        mem_be    = 4'hC;
        mem_req   = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("rst_busy_m_req", 32'(m_req), 32'd0);
        check_eq("rst_busy_m_ctl", {27'h0, m_we, m_be}, 32'd0);
        check_eq("rst_busy_m_addr", m_addr, 32'd0);
        check_eq("rst_busy_m_wdata", m_wdata, 32'd0);
        check_eq("rst_busy_rdata", mem_rdata | if_rdata, 32'd0);
        check_eq("rst_busy_mem_stall", 32'(mem_stall), 32'd1);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        exp_mem(1'b0, 32'h600, 32'h0, 4'hF);
        mem_access(1'b0, 32'h600, 32'h0, 4'hF);

        repeat (3) @(posedge clk);
        check_eq("grant_q_empty", 32'(grant_q.size()), 32'd0);
        check_eq("if_exp_empty", 32'(if_exp_q.size()), 32'd0);
        check_eq("mem_exp_empty", 32'(mem_exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
